// File: rtl/pc_gen_pkg.sv
// Shared encodings for the PC generator: next-PC source select and control FSM states.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_MRET   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT      = 2'b00,
    ST_RUN       = 2'b01,
    ST_TRAP_PEND = 2'b10
  } pc_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC target select and adders. With PC_MISALIGN_TRAP_EN the raw
// target is passed through and misalignment is flagged; otherwise targets are word-forced.
module pc_target_mux
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] raw;
  logic            is_jump;

  assign pc_plus4 = pc + XLEN'(PC_STEP);

  always_comb begin
    raw     = pc_plus4;
    is_jump = 1'b0;
    case (pc_sel)
      PC_SEQ:    raw = pc_plus4;
      PC_BRANCH: begin raw = pc + imm_ext; is_jump = 1'b1; end
      PC_JALR:   begin raw = (rs1 + imm_ext) & ~XLEN'(1); is_jump = 1'b1; end
      PC_MRET:   raw = epc;
      default:   raw = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign target   = raw;
  assign misalign = is_jump & raw[1];
`else
  // Branch/JALR targets are snapped to a word boundary instead of trapping.
  assign target   = is_jump ? {raw[XLEN-1:2], 2'b00} : raw;
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/pc_gen_unit.sv
// Program counter generator: BOOT/RUN/TRAP_PEND control, trap entry/return and redirect.
// Misaligned branch/JALR targets trap only when PC_MISALIGN_TRAP_EN is defined.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            load,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] ImmExt,
  input  logic [XLEN-1:0] rs1,
  input  logic            trap_req,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            redirect,
  output logic            misalign
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] target;
  logic            tgt_mis;

  pc_target_mux #(.XLEN(XLEN)) u_mux (
    .pc       (pc_q),
    .pc_sel   (pc_sel),
    .imm_ext  (ImmExt),
    .rs1      (rs1),
    .epc      (epc_q),
    .pc_plus4 (pc_plus4),
    .target   (target),
    .misalign (tgt_mis)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (load) begin
          if (trap_req || tgt_mis) begin
            epc_d      = pc_q;
            pc_d       = TRAP_VECTOR;
            redirect_d = 1'b1;
            misalign_d = tgt_mis & ~trap_req;
          end else begin
            pc_d       = target;
            redirect_d = (pc_sel != PC_SEQ);
          end
        end else if (trap_req) begin
          state_d = ST_TRAP_PEND;
        end
      end
      ST_TRAP_PEND: begin
        // epc is the PC held through the stall, not the one at request time (same value).
        if (load) begin
          epc_d      = pc_q;
          pc_d       = TRAP_VECTOR;
          redirect_d = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

  assign PC       = pc_q;
  assign epc      = epc_q;
  assign redirect = redirect_q;
  assign misalign = misalign_q;

endmodule
